// File: rtl/compress_pkg.sv
// Shared types and constants for the token-table instruction compressor.
// Imported by the CAM, the handshake interface and the packer top.
package compress_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int TOKEN_BITS = 4;
  localparam int NUM_TOKENS = 2**TOKEN_BITS - 1;
  localparam int CNT_WIDTH  = 16;
  localparam int MISS_BITS  = TOKEN_BITS + DATA_WIDTH;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH;
  localparam int FILL_WIDTH = $clog2(ACC_WIDTH + 1);

  typedef logic [TOKEN_BITS-1:0] token_idx_t;
  typedef logic [DATA_WIDTH-1:0] instr_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [ACC_WIDTH-1:0]  acc_t;
  typedef logic [FILL_WIDTH-1:0] fill_t;

  localparam token_idx_t ESCAPE = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT,
    FLUSH
  } state_e;
endpackage

// File: rtl/instr_compressor_if.sv
// Bundle of table-load, input-stream, output-stream and status signals
// between the compressor and its producer/consumer.
interface instr_compressor_if;
  import compress_pkg::*;

  logic       tbl_we;
  token_idx_t tbl_addr;
  instr_t     tbl_data;
  logic       in_valid;
  logic       in_ready;
  instr_t     in_data;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  instr_t     out_data;
  logic       out_last;
  logic       busy;
  cnt_t       hit_count;
  cnt_t       miss_count;

  modport master (
    output tbl_we, tbl_addr, tbl_data,
    output in_valid, in_data, flush,
    output out_ready,
    input  in_ready, out_valid, out_data,
    input  out_last, busy, hit_count, miss_count
  );

  modport slave (
    input  tbl_we, tbl_addr, tbl_data,
    input  in_valid, in_data, flush,
    input  out_ready,
    output in_ready, out_valid, out_data,
    output out_last, busy, hit_count, miss_count
  );
endinterface

// File: rtl/token_cam.sv
// Token table: registered entries with a write port and a parallel
// lookup whose priority encoder favours the lowest matching index.
module token_cam
  import compress_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  token_idx_t waddr,
  input  instr_t     wdata,
  input  instr_t     key,
  output logic       hit,
  output token_idx_t idx
);

  instr_t                data_q [NUM_TOKENS];
  instr_t                data_d [NUM_TOKENS];
  logic [NUM_TOKENS-1:0] vld_q;
  logic [NUM_TOKENS-1:0] vld_d;

  // No entry exists at ESCAPE, so writes there fall through untouched.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    for (int i = 0; i < NUM_TOKENS; i++) begin
      if (we && waddr == token_idx_t'(i)) begin
        data_d[i] = wdata;
        vld_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '{default: '0};
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  always_comb begin
    hit = 1'b0;
    idx = ESCAPE;
    for (int i = NUM_TOKENS - 1; i >= 0; i--) begin
      if (vld_q[i] && data_q[i] == key) begin
        hit = 1'b1;
        idx = token_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/instr_compressor.sv
// Streaming instruction compressor: token hits become 4-bit codes, misses
// become ESCAPE plus the raw word, packed MSB-first into 32-bit words.
module instr_compressor
  import compress_pkg::*;
(
  input logic               clk,
  input logic               reset,
  instr_compressor_if.slave bus
);

  localparam fill_t WORD = fill_t'(DATA_WIDTH);
  localparam int    PAD  = ACC_WIDTH - MISS_BITS;

  acc_t   acc_q, acc_d;
  fill_t  fill_q, fill_d;
  logic   flush_pend_q, flush_pend_d;
  logic   out_valid_q, out_valid_d;
  logic   out_last_q, out_last_d;
  instr_t out_data_q, out_data_d;
  cnt_t   hit_q, hit_d;
  cnt_t   miss_q, miss_d;
  state_e state_q, state_d;

  logic       hit;
  token_idx_t idx;
  logic       in_fire;
  logic       out_fire;
  acc_t       code;

  token_cam u_cam (
    .clk   (clk),
    .reset (reset),
    .we    (bus.tbl_we),
    .waddr (bus.tbl_addr),
    .wdata (bus.tbl_data),
    .key   (bus.in_data),
    .hit   (hit),
    .idx   (idx)
  );

  assign bus.in_ready   = (state_q == IDLE) || (state_q == ACCUM);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_data   = out_data_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  always_comb begin
    acc_d        = acc_q;
    fill_d       = fill_q;
    flush_pend_d = flush_pend_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    code = hit ? {idx, {(ACC_WIDTH-TOKEN_BITS){1'b0}}}
               : {ESCAPE, bus.in_data, {PAD{1'b0}}};

    // Pop before append; a short final word also ends the flush.
    if (out_fire) begin
      acc_d = acc_q << DATA_WIDTH;
      if (fill_q > WORD) begin
        fill_d = fill_q - WORD;
      end else begin
        fill_d       = '0;
        flush_pend_d = 1'b0;
      end
    end

    if (in_fire) begin
      acc_d  = acc_d | (code >> fill_d);
      fill_d = fill_d + (hit ? fill_t'(TOKEN_BITS)
                             : fill_t'(MISS_BITS));
      if (hit && hit_q != '1) begin
        hit_d = hit_q + cnt_t'(1);
      end
      if (!hit && miss_q != '1) begin
        miss_d = miss_q + cnt_t'(1);
      end
    end

    if (bus.flush && !flush_pend_q && fill_d != '0) begin
      flush_pend_d = 1'b1;
    end

    out_valid_d = (fill_d >= WORD) ||
                  (flush_pend_d && fill_d != '0);
    out_last_d  = flush_pend_d && fill_d != '0 &&
                  fill_d <= WORD;
    out_data_d  = acc_d[ACC_WIDTH-1 -: DATA_WIDTH];

    state_d = IDLE;
    unique case (1'b1)
      flush_pend_d:
        state_d = FLUSH;
      !flush_pend_d && fill_d >= WORD:
        state_d = EMIT;
      !flush_pend_d && fill_d != '0 && fill_d < WORD:
        state_d = ACCUM;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      state_q      <= IDLE;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_instr_compressor.sv
// Bench for instr_compressor: vector table, hand sequences and a
// scoreboard of packed words built from a bit-level reference queue.
module tb_instr_compressor;
  import compress_pkg::*;

  typedef struct {
    instr_t data;
    logic   last;
  } exp_t;

  typedef struct {
    instr_t     data;
    logic       hit;
    token_idx_t code;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  instr_compressor_if bus ();

  instr_compressor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  exp_t   exp_q[$];
  exp_t   e;
  bit     bits[$];
  instr_t got_q[$];
  logic   last_last;
  instr_t mtbl[NUM_TOKENS];
  logic   mvld[NUM_TOKENS];
  vec_t   vecs[7];
  cnt_t   h0, m0;
  logic   bad;
  instr_t x;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, expv);
    end
  endtask

  function automatic token_idx_t lookup(input instr_t d);
    for (int i = 0; i < NUM_TOKENS; i++)
      if (mvld[i] && mtbl[i] == d)
        return token_idx_t'(i);
    return ESCAPE;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_TOKENS; i++) begin
      mvld[i] = 1'b0;
      mtbl[i] = '0;
    end
    exp_q.delete();
    bits.delete();
  endtask

  task automatic push_code(input token_idx_t c, input instr_t d);
    instr_t w;
    for (int i = TOKEN_BITS - 1; i >= 0; i--)
      bits.push_back(c[i]);
    if (c == ESCAPE)
      for (int i = DATA_WIDTH - 1; i >= 0; i--)
        bits.push_back(d[i]);
    while (bits.size() >= DATA_WIDTH) begin
      for (int i = DATA_WIDTH - 1; i >= 0; i--)
        w[i] = bits.pop_front();
      exp_q.push_back('{w, 1'b0});
    end
  endtask

  task automatic model_flush();
    instr_t w;
    if (bits.size() > 0) begin
      for (int i = DATA_WIDTH - 1; i >= 0; i--)
        w[i] = (bits.size() > 0) ? bits.pop_front() : 1'b0;
      exp_q.push_back('{w, 1'b1});
    end
  endtask

  // Monitor: compares each accepted word with the scoreboard head.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      last_last = bus.out_last;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", bus.out_data, 32'hxxxxxxxx);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_last", 32'(bus.out_last), 32'(e.last));
      end
    end
  end

  task automatic tbl_write(input token_idx_t a, input instr_t d);
    bus.tbl_we   = 1'b1;
    bus.tbl_addr = a;
    bus.tbl_data = d;
    @(posedge clk); #1;
    bus.tbl_we = 1'b0;
    if (a != ESCAPE) begin
      mtbl[int'(a)] = d;
      mvld[int'(a)] = 1'b1;
    end
  endtask

  task automatic send_code(input instr_t d, input token_idx_t c);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    chk("send_ready", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) push_code(c, d);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input instr_t d);
    send_code(d, lookup(d));
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    model_flush();
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"},
        32'(bus.busy || exp_q.size() != 0), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h1EFF2FE1, 1'b1, 4'h3};
    vecs[1] = '{32'hCAFEF00D, 1'b0, 4'hF};
    vecs[2] = '{32'hE3A00004, 1'b1, 4'h4};
    vecs[3] = '{32'hE3A00000, 1'b1, 4'h0};
    vecs[4] = '{32'h12345678, 1'b0, 4'hF};
    vecs[5] = '{32'hE3A00007, 1'b1, 4'h7};
    vecs[6] = '{32'h1EFF2FE1, 1'b1, 4'h3};

    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    model_clear();

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hits", 32'(bus.hit_count), 32'd0);
    chk("rst_misses", 32'(bus.miss_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Miss into an empty table, then flush the 4-bit tail.
    got_q.delete();
    send(32'hDEADBEEF);
    do_flush();
    wait_idle("miss");
    chk("miss_words", 32'(got_q.size()), 32'd2);
    chk("miss_w0", got_q[0], 32'hFDEADBEE);
    chk("miss_w1", got_q[1], 32'hF0000000);
    chk("miss_last", 32'(last_last), 32'd1);
    chk("miss_cnt", 32'(bus.miss_count), 32'd1);

    // Eight hits pack into exactly one word.
    for (int k = 0; k < 8; k++)
      tbl_write(token_idx_t'(k), 32'hE3A00000 + 32'(k));
    got_q.delete();
    for (int k = 0; k < 8; k++)
      send(32'hE3A00000 + 32'(k));
    wait_idle("hits");
    chk("hits_words", 32'(got_q.size()), 32'd1);
    chk("hits_w0", got_q[0], 32'h01234567);
    chk("hits_last", 32'(last_last), 32'd0);
    chk("hits_cnt", 32'(bus.hit_count), 32'd8);

    // Backpressure with a full word waiting.
    bus.out_ready = 1'b0;
    got_q.delete();
    for (int k = 7; k >= 0; k--)
      send(32'hE3A00000 + 32'(k));
    @(negedge clk);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold", bus.out_data, 32'h76543210);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle("bp");
    chk("bp_words", 32'(got_q.size()), 32'd1);
    chk("bp_cnt", 32'(bus.hit_count), 32'd16);

    // Six hits plus one miss reach fill 60, then flush.
    bus.out_ready = 1'b0;
    got_q.delete();
    for (int k = 0; k < 6; k++)
      send(32'hE3A00000 + 32'(k));
    send(32'h00C0FFEE);
    @(negedge clk);
    chk("f60_in_ready", 32'(bus.in_ready), 32'd0);
    chk("f60_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    do_flush();
    @(negedge clk);
    chk("f60_last0", 32'(bus.out_last), 32'd0);
    @(posedge clk); #1;
    pop_one();
    @(negedge clk);
    chk("f60_valid1", 32'(bus.out_valid), 32'd1);
    chk("f60_last1", 32'(bus.out_last), 32'd1);
    chk("f60_in_ready1", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    pop_one();
    @(negedge clk);
    chk("f60_in_ready2", 32'(bus.in_ready), 32'd1);
    chk("f60_valid2", 32'(bus.out_valid), 32'd0);
    chk("f60_busy", 32'(bus.busy), 32'd0);
    chk("f60_w0", got_q[0], 32'h012345F0);
    chk("f60_w1", got_q[1], 32'h0C0FFEE0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // Table rules via the vector table.
    tbl_write(4'd3, 32'h1EFF2FE1);
    tbl_write(4'd5, 32'h1EFF2FE1);
    tbl_write(4'd15, 32'hCAFEF00D);
    for (int i = 0; i < 7; i++) begin
      h0 = bus.hit_count;
      m0 = bus.miss_count;
      send_code(vecs[i].data, vecs[i].code);
      @(negedge clk);
      chk($sformatf("vec%0d_hit", i),
          32'(bus.hit_count - h0), 32'(vecs[i].hit));
      chk($sformatf("vec%0d_miss", i),
          32'(bus.miss_count - m0), 32'(!vecs[i].hit));
      @(posedge clk); #1;
    end
    do_flush();
    wait_idle("vec");

    // Table write in the same cycle as a matching input.
    x  = 32'h0BADC0DE;
    m0 = bus.miss_count;
    h0 = bus.hit_count;
    bus.tbl_we   = 1'b1;
    bus.tbl_addr = 4'd2;
    bus.tbl_data = x;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    @(negedge clk);
    chk("wr_same_ready", 32'(bus.in_ready), 32'd1);
    push_code(lookup(x), x);
    mtbl[2] = x;
    mvld[2] = 1'b1;
    @(posedge clk); #1;
    bus.tbl_we   = 1'b0;
    bus.in_valid = 1'b0;
    chk("wr_same_miss", 32'(bus.miss_count - m0), 32'd1);
    send(x);
    chk("wr_after_hit", 32'(bus.hit_count - h0), 32'd1);
    do_flush();
    wait_idle("wr_same");

    // Flush with nothing buffered is a no-op.
    chk("f0_busy_pre", 32'(bus.busy), 32'd0);
    do_flush();
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      bad = bad | bus.busy | bus.out_valid;
    end
    chk("f0_quiet", 32'(bad), 32'd0);
    @(posedge clk); #1;

    // Reset with fill 40 and a word waiting.
    bus.out_ready = 1'b0;
    send(32'hE3A00001);
    send(32'hDEADBEEF);
    @(negedge clk);
    chk("rm_valid_pre", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rm_valid", 32'(bus.out_valid), 32'd0);
    chk("rm_hits", 32'(bus.hit_count), 32'd0);
    chk("rm_misses", 32'(bus.miss_count), 32'd0);
    chk("rm_busy", 32'(bus.busy), 32'd0);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    got_q.delete();
    send(32'hE3A00001);
    chk("rm_esc_miss", 32'(bus.miss_count), 32'd1);
    chk("rm_esc_hit", 32'(bus.hit_count), 32'd0);
    do_flush();
    wait_idle("rm");
    chk("rm_w0", got_q[0], 32'hFE3A0000);
    chk("rm_w1", got_q[1], 32'h10000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
